// File: rtl/fifo_share_arbiter_if.sv
// Bundles the producer/consumer request side and the FIFO strobe side of
// the shared-FIFO arbiter; the arbiter connects through the slave modport.
interface fifo_share_arbiter_if #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] din_all;
  logic           rd_req;
  logic [N-1:0]   gnt;
  logic           rd_valid;
  logic           fifo_wen;
  logic           fifo_ren;
  logic [W-1:0]   fifo_din;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

  modport master (
    output req, din_all, rd_req,
    input  gnt, rd_valid, fifo_wen, fifo_ren, fifo_din, count, full, empty
  );

  modport slave (
    input  req, din_all, rd_req,
    output gnt, rd_valid, fifo_wen, fifo_ren, fifo_din, count, full, empty
  );
endinterface

// File: rtl/fifo_share_arbiter.sv
// Serialises N producers and one consumer onto a single-access FIFO:
// reads win, writes are granted round-robin, occupancy is mirrored locally.
module fifo_share_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  fifo_share_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  gnt_q, gnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic          fifo_wen_q, fifo_wen_d;
  logic          fifo_ren_q, fifo_ren_d;
  logic [W-1:0]  fifo_din_q, fifo_din_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rr_q, rr_d;

  logic [W-1:0]  din_arr [N];
  logic          found;
  logic [PW-1:0] winner;

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign din_arr[gi] = bus.din_all[gi*W +: W];
  end

  // First set request at or above the rr pointer, wrapping modulo N.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req[(int'(rr_q) + k) % N]) begin
        found  = 1'b1;
        winner = PW'((int'(rr_q) + k) % N);
      end
    end
  end

  always_comb begin
    gnt_d      = '0;
    fifo_wen_d = 1'b0;
    fifo_ren_d = 1'b0;
    fifo_din_d = fifo_din_q;
    count_d    = count_q;
    rr_d       = rr_q;
    rd_valid_d = fifo_ren_q;
    // Read priority mirrors the FIFO, so wen and ren are never both issued.
    if (bus.rd_req && count_q != '0) begin
      fifo_ren_d = 1'b1;
      count_d    = count_q - CW'(1);
    end else if (found && count_q < CW'(DEPTH)) begin
      gnt_d[winner] = 1'b1;
      fifo_wen_d    = 1'b1;
      fifo_din_d    = din_arr[winner];
      count_d       = count_q + CW'(1);
      rr_d          = (winner == PW'(N - 1)) ? '0 : winner + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      rd_valid_q <= 1'b0;
      fifo_wen_q <= 1'b0;
      fifo_ren_q <= 1'b0;
      fifo_din_q <= '0;
      count_q    <= '0;
      rr_q       <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      fifo_wen_q <= fifo_wen_d;
      fifo_ren_q <= fifo_ren_d;
      fifo_din_q <= fifo_din_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.fifo_wen = fifo_wen_q;
  assign bus.fifo_ren = fifo_ren_q;
  assign bus.fifo_din = fifo_din_q;
  assign bus.count    = count_q;
  assign bus.full     = (count_q == CW'(DEPTH));
  assign bus.empty    = (count_q == '0);
endmodule

// File: tb/tb_fifo_share_arbiter.sv
// Bench for fifo_share_arbiter: directed table of sequences, then random
// traffic against a queue-based reference model and a behavioural FIFO.
module tb_fifo_share_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_share_arbiter_if #(.N(N), .W(W), .DEPTH(DEPTH)) arb ();

  fifo_share_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb.slave)
  );

  // Behavioural FIFO fed by the arbiter strobes; read wins when both high.
  logic [W-1:0] fq [$];
  logic [W-1:0] fifo_dout;
  logic         fifo_err;
  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      fifo_dout <= '0;
      fifo_err  <= 1'b0;
    end else if (arb.fifo_ren) begin
      if (fq.size() == 0) fifo_err <= 1'b1;
      else fifo_dout <= fq.pop_front();
    end else if (arb.fifo_wen) begin
      if (fq.size() >= DEPTH) fifo_err <= 1'b1;
      else fq.push_back(arb.fifo_din);
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state: occupancy, rr pointer, expected FIFO contents.
  int           m_count;
  int           m_rr;
  logic [W-1:0] m_q [$];
  bit           m_ren_prev;
  logic [W-1:0] m_rdata;
  logic [W-1:0] din_v [N];

  task automatic step(input logic r, input logic [N-1:0] rq, input logic rd, output int win);
    logic [N-1:0] e_gnt;
    logic [W-1:0] e_din;
    logic [W-1:0] e_rdata;
    bit e_wen, e_ren, e_rdv;
    win = -1;
    rst_n = r;
    arb.req = rq;
    arb.rd_req = rd;
    for (int i = 0; i < N; i++) arb.din_all[i*W +: W] = din_v[i];
    e_gnt = '0; e_wen = 0; e_ren = 0; e_din = '0;
    e_rdv = m_ren_prev;
    e_rdata = m_rdata;
    if (!r) begin
      m_count = 0; m_rr = 0; m_q.delete(); e_rdv = 0;
    end else if (rd && m_count > 0) begin
      e_ren = 1; m_rdata = m_q.pop_front(); m_count--;
    end else if (rq != 0 && m_count < DEPTH) begin
      for (int k = 0; k < N; k++)
        if (win < 0 && rq[(m_rr + k) % N]) win = (m_rr + k) % N;
      e_gnt[win] = 1'b1; e_wen = 1; e_din = din_v[win];
      m_q.push_back(din_v[win]); m_count++; m_rr = (win + 1) % N;
    end
    m_ren_prev = e_ren;
    @(posedge clk);
    #1;
    cyc++;
    chk("gnt", 32'(arb.gnt), 32'(e_gnt));
    chk("fifo_wen", 32'(arb.fifo_wen), 32'(e_wen));
    chk("fifo_ren", 32'(arb.fifo_ren), 32'(e_ren));
    if (e_wen) chk("fifo_din", 32'(arb.fifo_din), 32'(e_din));
    if (!r) chk("fifo_din_rst", 32'(arb.fifo_din), 32'd0);
    chk("count", 32'(arb.count), 32'(m_count));
    chk("full", 32'(arb.full), 32'(m_count == DEPTH));
    chk("empty", 32'(arb.empty), 32'(m_count == 0));
    chk("rd_valid", 32'(arb.rd_valid), 32'(e_rdv));
    if (e_rdv) chk("dout", 32'(fifo_dout), 32'(e_rdata));
    chk("fifo_err", 32'(fifo_err), 32'd0);
    if (win >= 0) din_v[win] = din_v[win] + 8'd4;
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rd;
    logic [3:0] gnt;
    logic       wen;
    logic       ren;
    logic [3:0] cnt;
    logic       rdv;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(logic r, logic [3:0] rq, logic rd, logic [3:0] g,
                              logic w, logic rn, logic [3:0] c, logic v);
    vec_t t;
    t.rst_n = r; t.req = rq; t.rd = rd; t.gnt = g;
    t.wen = w; t.ren = rn; t.cnt = c; t.rdv = v;
    tbl.push_back(t);
  endfunction

  initial begin
    int win;
    logic [N-1:0] pend;
    logic [3:0] seq [8];
    arb.req = '0;
    arb.rd_req = 1'b0;
    arb.din_all = '0;
    m_count = 0; m_rr = 0; m_ren_prev = 0; m_rdata = '0;
    for (int i = 0; i < N; i++) din_v[i] = 8'h10 + 8'(i);

    // Round-robin fill to full, then hold requests with no further grant.
    add(0, 4'h0, 0, 4'h0, 0, 0, 0, 0);
    seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    for (int i = 0; i < 8; i++) add(1, 4'hF, 0, seq[i], 1, 0, 4'(i + 1), 0);
    add(1, 4'hF, 0, 4'h0, 0, 0, 8, 0);
    // Drain in order, then read while empty.
    for (int i = 0; i < 8; i++) add(1, 4'h0, 1, 4'h0, 0, 1, 4'(7 - i), (i != 0));
    add(1, 4'h0, 0, 4'h0, 0, 0, 0, 1);
    add(1, 4'h0, 1, 4'h0, 0, 0, 0, 0);
    // Simultaneous read and write at count 3: read first, write next cycle.
    add(1, 4'h1, 0, 4'h1, 1, 0, 1, 0);
    add(1, 4'h2, 0, 4'h2, 1, 0, 2, 0);
    add(1, 4'h4, 0, 4'h4, 1, 0, 3, 0);
    add(1, 4'h4, 1, 4'h0, 0, 1, 2, 0);
    add(1, 4'h4, 0, 4'h4, 1, 0, 3, 1);
    // Reset during a grant at count 5; rr pointer must restart at 0.
    add(1, 4'h8, 0, 4'h8, 1, 0, 4, 0);
    add(1, 4'h1, 0, 4'h1, 1, 0, 5, 0);
    add(0, 4'h2, 0, 4'h0, 0, 0, 0, 0);
    add(1, 4'hF, 0, 4'h1, 1, 0, 1, 0);
    // Full with a waiting producer; one read frees a slot for the next cycle.
    for (int i = 0; i < 7; i++) add(1, 4'h2, 0, 4'h2, 1, 0, 4'(i + 2), 0);
    add(1, 4'h1, 0, 4'h0, 0, 0, 8, 0);
    add(1, 4'h1, 1, 4'h0, 0, 1, 7, 0);
    add(1, 4'h1, 0, 4'h1, 1, 0, 8, 1);
    add(0, 4'h0, 0, 4'h0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].rd, win);
      chk("tbl_gnt", 32'(arb.gnt), 32'(tbl[i].gnt));
      chk("tbl_wen", 32'(arb.fifo_wen), 32'(tbl[i].wen));
      chk("tbl_ren", 32'(arb.fifo_ren), 32'(tbl[i].ren));
      chk("tbl_count", 32'(arb.count), 32'(tbl[i].cnt));
      chk("tbl_rd_valid", 32'(arb.rd_valid), 32'(tbl[i].rdv));
      $display("row %0d rst_n=%b req=%b rd=%b -> gnt=%b wen=%b ren=%b count=%0d rd_valid=%b",
               i, tbl[i].rst_n, tbl[i].req, tbl[i].rd, arb.gnt, arb.fifo_wen,
               arb.fifo_ren, arb.count, arb.rd_valid);
    end

    // Random traffic: producers hold req/data until granted; read rate varies.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      logic r, rd;
      int rdp;
      rdp = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 50 : 90);
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          din_v[i] = 8'($urandom);
        end
      r  = ($urandom_range(0, 149) != 0);
      rd = ($urandom_range(0, 99) < rdp);
      step(r, pend, rd, win);
      if (win >= 0) pend[win] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_share_arbiter.md
Name: fifo_share_arbiter

Overview:
- Shares one 8-entry, 8-bit FIFO between N producers and a single consumer.
- The FIFO takes one access per cycle. When ren and wen are both high it performs the read only. It raises error on overflow or underflow.
- This arbiter serialises accesses so that read and write are never asserted in the same cycle. It picks a producer round-robin and mirrors the FIFO occupancy so the FIFO error output never asserts.
- It sits between the producer/consumer request logic and the FIFO's wen/ren/din ports.

Parameters:
- N, 4, number of producers.
- W, 8, data width; matches the FIFO din/dout width.
- DEPTH, 8, FIFO capacity; occupancy counter is clog2(DEPTH)+1 bits wide.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  in  N  producer write requests; producer i holds req[i] and its data until gnt[i] pulses.
- din_all  in  N*W  producer data; producer i drives bits [i*W +: W].
- rd_req  in  1  consumer read request; level, one pop per serviced cycle.
- gnt  out  N  one-hot, one-cycle pulse; aligned with fifo_wen.
- rd_valid  out  1  one-cycle pulse; FIFO dout holds popped data this cycle.
- fifo_wen  out  1  to FIFO wen; registered.
- fifo_ren  out  1  to FIFO ren; registered.
- fifo_din  out  W  to FIFO din; registered, valid while fifo_wen=1.
- count  out  clog2(DEPTH)+1  mirrored occupancy.
- full  out  1  high when count==DEPTH.
- empty  out  1  high when count==0.

Behaviour:
- Reset: gnt=0, rd_valid=0, fifo_wen=0, fifo_ren=0, fifo_din=0, count=0, rr pointer=0. Reset also clears FIFO state because rst_n is shared.
- Decision each edge, made from registered count and the current inputs:
  - READ when rd_req=1 and count>0. Sets fifo_ren=1 for the next cycle and count-=1. No grant issued.
  - Otherwise WRITE when any req bit is set and count<DEPTH.
    - Winner is the first set req bit searching from the rr pointer upward, wrapping modulo N.
    - Sets gnt[winner]=1, fifo_wen=1 and fifo_din=din_all[winner] for the next cycle; count+=1; rr pointer becomes winner+1 mod N.
  - Otherwise IDLE: all strobes 0, count unchanged.
- Read priority matches the FIFO's own priority. The arbiter never asserts fifo_wen and fifo_ren together.
- Latency:
  - req sampled at edge E gives gnt and fifo_wen high during E..E+1; the FIFO stores the data at E+1.
  - rd_req sampled at E gives fifo_ren during E..E+1; the FIFO updates dout at E+1; rd_valid is high during E+1..E+2.
- Occupancy arithmetic: count changes by exactly ±1 or 0 per cycle. Never below 0, never above DEPTH.
- Empty with rd_req=1: no fifo_ren; a pending write may be granted in the same cycle; no rd_valid.
- Full with req pending: no grant; requesters keep waiting; a read frees a slot and the next eligible cycle grants.
- Full and rd_req=1: read is performed; a write can be granted from the following cycle.
- Pending write under continuous rd_req with count>0: writes wait until count==0 or rd_req drops. Starvation under continuous reads is accepted.
- After a grant the producer drops req[i] on the next cycle. If req[i] is still high at the decision after gnt, it counts as a new request.
- Reset mid-operation: all strobes and count clear at that edge. An in-flight fifo_wen or fifo_ren is discarded, consistent with the FIFO reset.

Test Plan:
- Reset, then req=4'b1111 held, rd_req=0 -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000 on consecutive cycles; full=1 after 8 grants; no further gnt.
- Fill with producer data 0x10..0x17, then rd_req=1 for 8 cycles -> rd_valid pulses with FIFO dout 0x10..0x17 in order; empty=1 at end; FIFO error stays 0.
- rd_req=1 and req=4'b0100 in the same cycle at count=3 -> fifo_ren=1, fifo_wen=0, count 2. The next cycle, with rd_req=0, grants 0100 and count returns to 3.
- Empty, rd_req=1, req=0 -> no fifo_ren, no rd_valid, count stays 0.
- Full, req=4'b0001 held, then one read -> gnt[0] issued exactly one cycle after the read decision; count returns to 8.
- rst_n=0 during a grant cycle at count=5 -> next cycle count=0, all strobes 0, rr pointer=0.
